// File: rtl/ova_stream_accum_if.sv
// Stream bus for ova_stream_accum: element input stream and accumulated output stream.
interface ova_stream_accum_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 20
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;

  // Accumulator side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Producer/consumer side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/ova_stream_accum.sv
// Overlap-add stream accumulator: sums an NB x NB grid of BLK x BLK blocks, overlapping by OVL
// elements, into an OUT x OUT frame with saturation, then streams the frame out in raster order.
module ova_stream_accum #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned BLK    = 3,
  parameter int unsigned OVL    = 1,
  parameter int unsigned NB     = 2
) (
  input  logic                clk,
  input  logic                reset,
  ova_stream_accum_if.slave   bus,
  output logic                sat_flag,
  output logic                busy
);

  localparam int unsigned STEP  = BLK - OVL;
  localparam int unsigned OUT   = NB * BLK - (NB - 1) * OVL;
  localparam int unsigned CELLS = OUT * OUT;
  localparam int unsigned AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned EW    = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StClear, StAccum, StDrain} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     er_q, er_d, ec_q, ec_d;
  logic [BW-1:0]     br_q, br_d, bc_q, bc_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;     // next buffer address to load into the output reg
  logic [AW-1:0]     pres_addr_q, pres_addr_d; // address of the element currently presented
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              sat_q, sat_d;

  logic [ACC_W-1:0]  buf_q [CELLS];

  logic              in_hs, out_hs, load, last_elem;
  logic [31:0]       tgt_row, tgt_col;
  logic [AW-1:0]     tgt_addr;
  logic [ACC_W-1:0]  cur;
  logic [ACC_W:0]    ext, sum;
  logic              ovf;
  logic [ACC_W-1:0]  acc_sat;

  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign sat_flag      = sat_q;
  assign busy          = (state_q != StAccum);

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = out_valid_q & bus.out_ready;
  // Refill the output register when it is empty or being consumed, until the last one is loaded.
  assign load   = (state_q == StDrain) && !(out_valid_q && out_last_q) &&
                  (!out_valid_q || bus.out_ready);

  assign last_elem = (er_q == EW'(BLK - 1)) && (ec_q == EW'(BLK - 1)) &&
                     (br_q == BW'(NB - 1)) && (bc_q == BW'(NB - 1));

  // Frame address of the current input element.
  assign tgt_row  = 32'(br_q) * STEP + 32'(er_q);
  assign tgt_col  = 32'(bc_q) * STEP + 32'(ec_q);
  assign tgt_addr = AW'(tgt_row * OUT + tgt_col);

  // Saturating add of the sign-extended sample into the target cell.
  always_comb begin
    cur     = buf_q[tgt_addr];
    ext     = {{(ACC_W + 1 - DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
    sum     = {cur[ACC_W-1], cur} + ext;
    ovf     = sum[ACC_W] ^ sum[ACC_W-1];
    acc_sat = sum[ACC_W-1:0];
    if (ovf) begin
      acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state and control datapath.
  always_comb begin
    state_d     = state_q;
    er_d        = er_q;
    ec_d        = ec_q;
    br_d        = br_q;
    bc_d        = bc_q;
    clr_addr_d  = clr_addr_q;
    rd_addr_d   = rd_addr_q;
    pres_addr_d = pres_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;

    unique case (state_q)
      StClear: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(CELLS - 1)) begin
          clr_addr_d = '0;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        if (in_hs) begin
          if (ovf) sat_d = 1'b1;
          if (ec_q != EW'(BLK - 1)) begin
            ec_d = ec_q + 1'b1;
          end else begin
            ec_d = '0;
            if (er_q != EW'(BLK - 1)) begin
              er_d = er_q + 1'b1;
            end else begin
              er_d = '0;
              if (bc_q != BW'(NB - 1)) begin
                bc_d = bc_q + 1'b1;
              end else begin
                bc_d = '0;
                br_d = (br_q != BW'(NB - 1)) ? br_q + 1'b1 : '0;
              end
            end
          end
          if (last_elem) begin
            state_d   = StDrain;
            rd_addr_d = '0;
          end
        end
      end
      StDrain: begin
        if (load) begin
          out_data_d  = buf_q[rd_addr_q];
          out_valid_d = 1'b1;
          out_last_d  = (rd_addr_q == AW'(CELLS - 1));
          pres_addr_d = rd_addr_q;
          rd_addr_d   = rd_addr_q + 1'b1;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (out_hs && out_last_q) begin
          state_d   = StAccum;
          sat_d     = 1'b0;
          rd_addr_d = '0;
          er_d      = '0;
          ec_d      = '0;
          br_d      = '0;
          bc_d      = '0;
        end
      end
      default: state_d = StClear;
    endcase

    if (reset) begin
      state_d     = StClear;
      er_d        = '0;
      ec_d        = '0;
      br_d        = '0;
      bc_d        = '0;
      clr_addr_d  = '0;
      rd_addr_d   = '0;
      pres_addr_d = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      sat_d       = 1'b0;
    end
  end

  // Control registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    er_q        <= er_d;
    ec_q        <= ec_d;
    br_q        <= br_d;
    bc_q        <= bc_d;
    clr_addr_q  <= clr_addr_d;
    rd_addr_q   <= rd_addr_d;
    pres_addr_q <= pres_addr_d;
    out_data_q  <= out_data_d;
    out_valid_q <= out_valid_d;
    out_last_q  <= out_last_d;
    sat_q       <= sat_d;
  end

  // Accumulation buffer: clear sweep, accumulate, and clear-on-read as elements leave.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) buf_q[clr_addr_q] <= '0;
      if (in_hs)              buf_q[tgt_addr]   <= acc_sat;
      if (out_hs)             buf_q[pres_addr_q] <= '0;
    end
  end

endmodule

// File: tb/tb_ova_stream_accum.sv
// Directed bench for ova_stream_accum: default instance plus an 8-bit saturating instance.
module tb_ova_stream_accum;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ova_stream_accum_if #(.DATA_W(16), .ACC_W(20)) if_a ();
  ova_stream_accum_if #(.DATA_W(8),  .ACC_W(8))  if_b ();
  logic sat_a, busy_a, sat_b, busy_b;

  ova_stream_accum u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .bus      (if_a),
    .sat_flag (sat_a),
    .busy     (busy_a)
  );

  ova_stream_accum #(.DATA_W(8), .ACC_W(8)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .bus      (if_b),
    .sat_flag (sat_b),
    .busy     (busy_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit sel     = 1'b0;

  logic               m_in_ready, m_out_valid, m_out_last, m_sat, m_busy;
  logic signed [31:0] m_out_data;

  // Observe whichever instance is under test.
  always_comb begin
    m_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
    m_out_valid = sel ? if_b.out_valid : if_a.out_valid;
    m_out_last  = sel ? if_b.out_last  : if_a.out_last;
    m_sat       = sel ? sat_b : sat_a;
    m_busy      = sel ? busy_b : busy_a;
    m_out_data  = sel ? {{24{if_b.out_data[7]}}, if_b.out_data}
                      : {{12{if_a.out_data[19]}}, if_a.out_data};
  end

  int exp_ones [25] = '{1, 1, 2, 1, 1,  1, 1, 2, 1, 1,  2, 2, 4, 2, 2,  1, 1, 2, 1, 1,
                        1, 1, 2, 1, 1};
  int exp_blk  [25] = '{1, 1, 3, 2, 2,  1, 1, 3, 2, 2,  4, 4, 10, 6, 6,  3, 3, 7, 4, 4,
                        3, 3, 7, 4, 4};
  int exp_sat  [25] = '{100, 100, 127, 100, 100,  100, 100, 127, 100, 100,
                        127, 127, 127, 127, 127,  100, 100, 127, 100, 100,
                        100, 100, 127, 100, 100};
  int exp_tab  [25];
  int frame    [36];
  bit pat      [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_in(input bit v, input int d);
    if (sel) begin
      if_b.in_valid = v;
      if_b.in_data  = 8'(d);
    end else begin
      if_a.in_valid = v;
      if_a.in_data  = 16'(d);
    end
  endtask

  task automatic set_out_ready(input bit r);
    if (sel) if_b.out_ready = r;
    else     if_a.out_ready = r;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 36; i++) frame[i] = v;
  endtask

  task automatic fill_blocks();
    for (int i = 0; i < 36; i++) frame[i] = i / 9 + 1;
  endtask

  // Count negedges with in_ready low, starting at the current one.
  task automatic count_clear(output int n);
    n = 0;
    while (!m_in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Offer frame elements 0..count-1; called and returns at a negedge.
  task automatic send_frame(input int count, input bit keep);
    int n;
    for (int i = 0; i < count; i++) begin
      drive_in(1'b1, frame[i]);
      n = 0;
      while (!m_in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        check("in_wait", m_in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    if (!keep) drive_in(1'b0, 0);
  endtask

  // Collect a full output frame against exp_tab.
  task automatic drain(input bit stall, input bit b2b, input bit exp_sat_flag);
    int idx = 0;
    int cyc = 0;
    bit r;
    while (idx < 25 && cyc < 400) begin
      r = stall ? pat[cyc % 4] : 1'b1;
      set_out_ready(r);
      if (b2b) check("in_ready_drain", m_in_ready, 0);
      if (m_out_valid) begin
        check($sformatf("out[%0d]", idx), m_out_data, exp_tab[idx]);
        if (r) begin
          check($sformatf("last[%0d]", idx), m_out_last, (idx == 24) ? 1 : 0);
          if (idx == 24) check("sat_in_frame", m_sat, exp_sat_flag);
          if (idx == 0) check("busy_drain", m_busy, 1);
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < 25) check("drain_count", idx, 25);
    check("post_valid", m_out_valid, 0);
    check("post_ready", m_in_ready, 1);
    check("post_busy", m_busy, 0);
    check("post_sat", m_sat, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_in_ready", m_in_ready, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_last", m_out_last, 0);
    check("rst_out_data", m_out_data, 0);
    check("rst_busy", m_busy, 1);
    check("rst_sat", m_sat, 0);

    reset = 1'b0;
    count_clear(n);
    check("clear_cycles", n, 25);

    // Frame of ones.
    fill_const(1);
    exp_tab = exp_ones;
    send_frame(36, 1'b0);
    drain(1'b0, 1'b0, 1'b0);

    // Per-block values.
    fill_blocks();
    exp_tab = exp_blk;
    send_frame(36, 1'b0);
    drain(1'b0, 1'b0, 1'b0);

    // Output stalls 1,0,0,1.
    fill_const(1);
    exp_tab = exp_ones;
    send_frame(36, 1'b0);
    drain(1'b1, 1'b0, 1'b0);

    // Abort a partial frame with reset.
    fill_const(5);
    send_frame(20, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", m_in_ready, 0);
    check("abort_busy", m_busy, 1);
    check("abort_out_valid", m_out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    count_clear(n);
    check("abort_clear_cycles", n, 25);
    fill_const(1);
    exp_tab = exp_ones;
    send_frame(36, 1'b0);
    drain(1'b0, 1'b0, 1'b0);

    // Back-to-back frames with in_valid held high through DRAIN.
    fill_const(1);
    send_frame(36, 1'b1);
    fill_blocks();
    drive_in(1'b1, frame[0]);
    drain(1'b0, 1'b1, 1'b0);
    send_frame(36, 1'b0);
    exp_tab = exp_blk;
    drain(1'b0, 1'b0, 1'b0);

    // 8-bit instance: saturation, then a clean frame.
    sel = 1'b1;
    @(negedge clk);
    fill_const(100);
    exp_tab = exp_sat;
    send_frame(36, 1'b0);
    drain(1'b0, 1'b0, 1'b1);
    fill_const(1);
    exp_tab = exp_ones;
    send_frame(36, 1'b0);
    drain(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
